// File: rtl/axi_mux_pkg.sv
// Shared types and helpers for the parametrised AXI4 read slave mux.
package axi_mux_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } dec_state_e;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/axi_decerr_rd_slave.sv
// Internal read slave that answers every accepted burst with DECERR beats of zero data.
module axi_decerr_rd_slave
    import axi_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 1024,
    parameter int ID_WIDTH   = 8,
    parameter int USER_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [7:0]            arlen,
    input  logic [USER_WIDTH-1:0] aruser,
    output logic                  rvalid,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic [USER_WIDTH-1:0] ruser,
    input  logic                  rready
);

    dec_state_e            state_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic                  rlast_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [USER_WIDTH-1:0] user_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_q;

    // Responder FSM: latch the request in IDLE, stream ARLEN+1 error beats in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            id_q      <= '0;
            user_q    <= '0;
            len_q     <= 8'd0;
            beat_q    <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arvalid) begin
                        state_q   <= ST_RESP;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rlast_q   <= (arlen == 8'd0);
                        id_q      <= arid;
                        user_q    <= aruser;
                        len_q     <= arlen;
                        beat_q    <= 8'd0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    if (rready && rlast_q) begin
                        state_q   <= ST_IDLE;
                        arready_q <= 1'b1;
                        rvalid_q  <= 1'b0;
                        rlast_q   <= 1'b0;
                    end else if (rready) begin
                        beat_q  <= beat_q + 8'd1;
                        rlast_q <= ((beat_q + 8'd1) == len_q);
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    arready_q <= 1'b1;
                    rvalid_q  <= 1'b0;
                    rlast_q   <= 1'b0;
                end
            endcase
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rid     = id_q;
    assign ruser   = user_q;
    assign rdata   = '0;
    assign rresp   = RESP_DECERR;

endmodule

// File: rtl/axi_rd_slave_mux_n.sv
// One AXI4 read master to NUM_SLAVES read slaves with address-window decode and in-order R return.
module axi_rd_slave_mux_n
    import axi_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 1024,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 8,
    parameter int USER_WIDTH = 8,
    parameter int NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE =
        {64'h0000_0000_0000_3000, 64'h0000_0000_0000_2000,
         64'h0000_0000_0000_1000, 64'h0000_0000_0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = {4{64'hFFFF_FFFF_FFFF_F000}},
    parameter int MAX_OUTST  = 8
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic [ID_WIDTH-1:0]              s2m_ARID,
    input  logic [ADDR_WIDTH-1:0]            s2m_ARADDR,
    input  logic [7:0]                       s2m_ARLEN,
    input  logic [2:0]                       s2m_ARSIZE,
    input  logic [1:0]                       s2m_ARBURST,
    input  logic                             s2m_ARLOCK,
    input  logic [3:0]                       s2m_ARCACHE,
    input  logic [2:0]                       s2m_ARPROT,
    input  logic [3:0]                       s2m_ARQOS,
    input  logic [3:0]                       s2m_ARREGION,
    input  logic [USER_WIDTH-1:0]            s2m_ARUSER,
    input  logic                             s2m_ARVALID,
    output logic                             s2m_ARREADY,
    output logic [ID_WIDTH-1:0]              s2m_RID,
    output logic [DATA_WIDTH-1:0]            s2m_RDATA,
    output logic [1:0]                       s2m_RRESP,
    output logic                             s2m_RLAST,
    output logic [USER_WIDTH-1:0]            s2m_RUSER,
    output logic                             s2m_RVALID,
    input  logic                             s2m_RREADY,
    output logic [NUM_SLAVES*ID_WIDTH-1:0]   m_ARID,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0] m_ARADDR,
    output logic [NUM_SLAVES*8-1:0]          m_ARLEN,
    output logic [NUM_SLAVES*3-1:0]          m_ARSIZE,
    output logic [NUM_SLAVES*2-1:0]          m_ARBURST,
    output logic [NUM_SLAVES-1:0]            m_ARLOCK,
    output logic [NUM_SLAVES*4-1:0]          m_ARCACHE,
    output logic [NUM_SLAVES*3-1:0]          m_ARPROT,
    output logic [NUM_SLAVES*4-1:0]          m_ARQOS,
    output logic [NUM_SLAVES*4-1:0]          m_ARREGION,
    output logic [NUM_SLAVES*USER_WIDTH-1:0] m_ARUSER,
    output logic [NUM_SLAVES-1:0]            m_ARVALID,
    input  logic [NUM_SLAVES-1:0]            m_ARREADY,
    input  logic [NUM_SLAVES*ID_WIDTH-1:0]   m_RID,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_RDATA,
    input  logic [NUM_SLAVES*2-1:0]          m_RRESP,
    input  logic [NUM_SLAVES-1:0]            m_RLAST,
    input  logic [NUM_SLAVES*USER_WIDTH-1:0] m_RUSER,
    input  logic [NUM_SLAVES-1:0]            m_RVALID,
    output logic [NUM_SLAVES-1:0]            m_RREADY
);

    localparam int SEL_W = clog2(NUM_SLAVES + 1);
    localparam int CNT_W = clog2(MAX_OUTST + 1);
    localparam logic [SEL_W-1:0] DEC_SEL = SEL_W'(NUM_SLAVES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

    logic [SEL_W-1:0]      sel;
    logic [SEL_W-1:0]      cur_d, cur_q;
    logic [CNT_W-1:0]      cnt_d, cnt_q;
    logic                  ar_go, tgt_ready, ar_hs, r_done, r_active;
    logic                  dec_arvalid, dec_arready, dec_rvalid, dec_rlast, dec_rready;
    logic [ID_WIDTH-1:0]   dec_rid;
    logic [DATA_WIDTH-1:0] dec_rdata;
    logic [1:0]            dec_rresp;
    logic [USER_WIDTH-1:0] dec_ruser;
    logic                  r_valid;

    assign m_ARID     = {NUM_SLAVES{s2m_ARID}};
    assign m_ARADDR   = {NUM_SLAVES{s2m_ARADDR}};
    assign m_ARLEN    = {NUM_SLAVES{s2m_ARLEN}};
    assign m_ARSIZE   = {NUM_SLAVES{s2m_ARSIZE}};
    assign m_ARBURST  = {NUM_SLAVES{s2m_ARBURST}};
    assign m_ARLOCK   = {NUM_SLAVES{s2m_ARLOCK}};
    assign m_ARCACHE  = {NUM_SLAVES{s2m_ARCACHE}};
    assign m_ARPROT   = {NUM_SLAVES{s2m_ARPROT}};
    assign m_ARQOS    = {NUM_SLAVES{s2m_ARQOS}};
    assign m_ARREGION = {NUM_SLAVES{s2m_ARREGION}};
    assign m_ARUSER   = {NUM_SLAVES{s2m_ARUSER}};

    // Window decode; scanning downward lets the lowest-index hit win.
    always_comb begin
        sel = DEC_SEL;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            sel = ((s2m_ARADDR & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                   SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) ? SEL_W'(i) : sel;
        end
    end

    // AR gating: a new target is only taken once every outstanding burst has drained.
    always_comb begin
        ar_go = ~ARESET & ((cnt_q == '0) ||
                ((cur_q == sel) && (cnt_q != CNT_MAX) && (sel != DEC_SEL)));
        tgt_ready = dec_arready;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            tgt_ready    = (sel == SEL_W'(i)) ? m_ARREADY[i] : tgt_ready;
            m_ARVALID[i] = s2m_ARVALID & ar_go & (sel == SEL_W'(i));
        end
        s2m_ARREADY = ar_go & tgt_ready;
        dec_arvalid = s2m_ARVALID & ar_go & (sel == DEC_SEL);
    end

    // R return mux follows the target of the bursts currently in flight.
    always_comb begin
        r_active  = ~ARESET & (cnt_q != '0);
        r_valid   = dec_rvalid;
        s2m_RID   = dec_rid;
        s2m_RDATA = dec_rdata;
        s2m_RRESP = dec_rresp;
        s2m_RLAST = dec_rlast;
        s2m_RUSER = dec_ruser;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (cur_q == SEL_W'(i)) begin
                r_valid     = m_RVALID[i];
                s2m_RID     = m_RID[i*ID_WIDTH +: ID_WIDTH];
                s2m_RDATA   = m_RDATA[i*DATA_WIDTH +: DATA_WIDTH];
                s2m_RRESP   = m_RRESP[i*2 +: 2];
                s2m_RLAST   = m_RLAST[i];
                s2m_RUSER   = m_RUSER[i*USER_WIDTH +: USER_WIDTH];
                m_RREADY[i] = s2m_RREADY & r_active;
            end else begin
                m_RREADY[i] = 1'b0;
            end
        end
        s2m_RVALID = r_valid & r_active;
        dec_rready = s2m_RREADY & r_active & (cur_q == DEC_SEL);
    end

    // Outstanding-burst tracker next state.
    always_comb begin
        ar_hs  = s2m_ARVALID & s2m_ARREADY;
        r_done = s2m_RVALID & s2m_RREADY & s2m_RLAST;
        cur_d  = ar_hs ? sel : cur_q;
        case ({ar_hs, r_done})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Tracker state registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt_q <= '0;
            cur_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            cur_q <= cur_d;
        end
    end

    axi_decerr_rd_slave #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .USER_WIDTH (USER_WIDTH)
    ) u_decerr (
        .clk     (ACLK),
        .rst     (ARESET),
        .arvalid (dec_arvalid),
        .arready (dec_arready),
        .arid    (s2m_ARID),
        .arlen   (s2m_ARLEN),
        .aruser  (s2m_ARUSER),
        .rvalid  (dec_rvalid),
        .rid     (dec_rid),
        .rdata   (dec_rdata),
        .rresp   (dec_rresp),
        .rlast   (dec_rlast),
        .ruser   (dec_ruser),
        .rready  (dec_rready)
    );

endmodule

// File: tb/tb_axi_rd_slave_mux_n.sv
// Directed bench for axi_rd_slave_mux_n: decode, ordering, DECERR responder, limits and reset.
module tb_axi_rd_slave_mux_n;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 64;
    localparam int IW = 8;
    localparam int UW = 8;

    logic            ACLK, ARESET;
    logic [IW-1:0]   s2m_ARID;
    logic [AW-1:0]   s2m_ARADDR;
    logic [7:0]      s2m_ARLEN;
    logic [2:0]      s2m_ARSIZE;
    logic [1:0]      s2m_ARBURST;
    logic            s2m_ARLOCK;
    logic [3:0]      s2m_ARCACHE, s2m_ARQOS, s2m_ARREGION;
    logic [2:0]      s2m_ARPROT;
    logic [UW-1:0]   s2m_ARUSER;
    logic            s2m_ARVALID, s2m_ARREADY;
    logic [IW-1:0]   s2m_RID;
    logic [DW-1:0]   s2m_RDATA;
    logic [1:0]      s2m_RRESP;
    logic            s2m_RLAST, s2m_RVALID, s2m_RREADY;
    logic [N*IW-1:0] m_ARID;
    logic [N*AW-1:0] m_ARADDR;
    logic [N*8-1:0]  m_ARLEN;
    logic [N*3-1:0]  m_ARSIZE, m_ARPROT;
    logic [N*2-1:0]  m_ARBURST;
    logic [N-1:0]    m_ARLOCK;
    logic [N*4-1:0]  m_ARCACHE, m_ARQOS, m_ARREGION;
    logic [N*UW-1:0] m_ARUSER;
    logic [N-1:0]    m_ARVALID, m_ARREADY;
    logic [N*IW-1:0] m_RID;
    logic [N*DW-1:0] m_RDATA;
    logic [N*2-1:0]  m_RRESP;
    logic [N-1:0]    m_RLAST;
    logic [N*UW-1:0] m_RUSER;
    logic [N-1:0]    m_RVALID, m_RREADY;

    int n_checks = 0;
    int n_errors = 0;

    axi_rd_slave_mux_n #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .ID_WIDTH (IW), .USER_WIDTH (UW), .NUM_SLAVES (N),
        .SLV_BASE   ({64'h3000, 64'h2000, 64'h1000, 64'h0}),
        .SLV_MASK   ({4{64'hFFFF_FFFF_FFFF_F000}}),
        .MAX_OUTST  (8)
    ) dut (
        .ACLK (ACLK), .ARESET (ARESET),
        .s2m_ARID (s2m_ARID), .s2m_ARADDR (s2m_ARADDR), .s2m_ARLEN (s2m_ARLEN),
        .s2m_ARSIZE (s2m_ARSIZE), .s2m_ARBURST (s2m_ARBURST), .s2m_ARLOCK (s2m_ARLOCK),
        .s2m_ARCACHE (s2m_ARCACHE), .s2m_ARPROT (s2m_ARPROT), .s2m_ARQOS (s2m_ARQOS),
        .s2m_ARREGION (s2m_ARREGION), .s2m_ARUSER (s2m_ARUSER),
        .s2m_ARVALID (s2m_ARVALID), .s2m_ARREADY (s2m_ARREADY),
        .s2m_RID (s2m_RID), .s2m_RDATA (s2m_RDATA), .s2m_RRESP (s2m_RRESP),
        .s2m_RLAST (s2m_RLAST), .s2m_RUSER (), .s2m_RVALID (s2m_RVALID), .s2m_RREADY (s2m_RREADY),
        .m_ARID (m_ARID), .m_ARADDR (m_ARADDR), .m_ARLEN (m_ARLEN), .m_ARSIZE (m_ARSIZE),
        .m_ARBURST (m_ARBURST), .m_ARLOCK (m_ARLOCK), .m_ARCACHE (m_ARCACHE), .m_ARPROT (m_ARPROT),
        .m_ARQOS (m_ARQOS), .m_ARREGION (m_ARREGION), .m_ARUSER (m_ARUSER),
        .m_ARVALID (m_ARVALID), .m_ARREADY (m_ARREADY),
        .m_RID (m_RID), .m_RDATA (m_RDATA), .m_RRESP (m_RRESP), .m_RLAST (m_RLAST),
        .m_RUSER (m_RUSER), .m_RVALID (m_RVALID), .m_RREADY (m_RREADY)
    );

    logic [UW-1:0] s2m_RUSER_obs;
    assign s2m_RUSER_obs = dut.s2m_RUSER;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic ar_drive(input logic v, input logic [63:0] a, input logic [7:0] id,
                            input logic [7:0] len, input logic [7:0] user);
        s2m_ARVALID = v;
        s2m_ARADDR  = a;
        s2m_ARID    = id;
        s2m_ARLEN   = len;
        s2m_ARUSER  = user;
    endtask

    task automatic slv_r(input int s, input logic v, input logic last,
                         input logic [63:0] d, input logic [7:0] id);
        m_RVALID[s]          = v;
        m_RLAST[s]           = last;
        m_RDATA[s*DW +: DW]  = d;
        m_RID[s*IW +: IW]    = id;
    endtask

    initial begin
        ARESET = 1'b1;
        s2m_ARSIZE = 3'd3; s2m_ARBURST = 2'b01; s2m_ARLOCK = 1'b0; s2m_ARCACHE = 4'd0;
        s2m_ARPROT = 3'd0; s2m_ARQOS = 4'd0; s2m_ARREGION = 4'd0;
        ar_drive(1'b1, 64'h1004, 8'h11, 8'd3, 8'h00);
        s2m_RREADY = 1'b1;
        m_ARREADY = 4'b1111;
        m_RID = '0; m_RDATA = '0; m_RRESP = '0; m_RLAST = '0; m_RUSER = '0; m_RVALID = '0;
        cyc(); cyc();

        // reset state, with a live request and RREADY held high
        settle();
        chk("rst_arready", s2m_ARREADY, 1'b0);
        chk("rst_m_arvalid", m_ARVALID, 4'b0000);
        chk("rst_rvalid", s2m_RVALID, 1'b0);
        chk("rst_m_rready", m_RREADY, 4'b0000);
        chk("rst_cnt", dut.cnt_q, 4'd0);

        // 1: burst of 4 to slave 1
        ARESET = 1'b0;
        settle();
        chk("t1_m_arvalid", m_ARVALID, 4'b0010);
        chk("t1_arready", s2m_ARREADY, 1'b1);
        cyc();
        ar_drive(1'b0, 64'h0, 8'h00, 8'd0, 8'h00);
        slv_r(0, 1'b1, 1'b1, 64'hDEAD, 8'hEE);
        for (int b = 0; b < 4; b++) begin
            slv_r(1, 1'b1, (b == 3), 64'hA0 + 64'(b), 8'h11);
            settle();
            chk("t1_cnt", dut.cnt_q, 4'd1);
            chk("t1_rvalid", s2m_RVALID, 1'b1);
            chk("t1_rdata", s2m_RDATA, 64'hA0 + 64'(b));
            chk("t1_rid", s2m_RID, 8'h11);
            chk("t1_rlast", s2m_RLAST, (b == 3));
            chk("t1_m_rready", m_RREADY, 4'b0010);
            cyc();
        end
        settle();
        chk("t1_cnt_done", dut.cnt_q, 4'd0);
        chk("t1_idle_rvalid", s2m_RVALID, 1'b0);
        chk("t1_idle_m_rready", m_RREADY, 4'b0000);
        slv_r(0, 1'b0, 1'b0, 64'h0, 8'h00);
        slv_r(1, 1'b0, 1'b0, 64'h0, 8'h00);

        // 2: unmapped read answered by the DECERR responder; a second one must wait
        ar_drive(1'b1, 64'h9000, 8'h5A, 8'd2, 8'h3C);
        settle();
        chk("t2_m_arvalid", m_ARVALID, 4'b0000);
        chk("t2_arready", s2m_ARREADY, 1'b1);
        cyc();
        for (int b = 0; b < 3; b++) begin
            settle();
            chk("t2_rvalid", s2m_RVALID, 1'b1);
            chk("t2_rresp", s2m_RRESP, 2'b11);
            chk("t2_rid", s2m_RID, 8'h5A);
            chk("t2_ruser", s2m_RUSER_obs, 8'h3C);
            chk("t2_rdata", s2m_RDATA, 64'h0);
            chk("t2_rlast", s2m_RLAST, (b == 2));
            chk("t2_second_blocked", s2m_ARREADY, 1'b0);
            chk("t2_no_m_arvalid", m_ARVALID, 4'b0000);
            cyc();
        end
        settle();
        chk("t2_rvalid_done", s2m_RVALID, 1'b0);
        chk("t2_cnt_done", dut.cnt_q, 4'd0);
        chk("t2_dec_idle", s2m_ARREADY, 1'b1);
        ar_drive(1'b0, 64'h0, 8'h00, 8'd0, 8'h00);

        // 3: eight outstanding to slave 0, ninth blocked until first RLAST
        ar_drive(1'b1, 64'h10, 8'h01, 8'd0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("t3_accept", s2m_ARREADY, 1'b1);
            cyc();
        end
        settle();
        chk("t3_cnt_full", dut.cnt_q, 4'd8);
        chk("t3_ninth_blocked", s2m_ARREADY, 1'b0);
        chk("t3_ninth_no_valid", m_ARVALID, 4'b0000);
        cyc();
        slv_r(0, 1'b1, 1'b1, 64'h1, 8'h01);
        settle();
        chk("t3_still_blocked", s2m_ARREADY, 1'b0);
        chk("t3_rvalid", s2m_RVALID, 1'b1);
        cyc();
        slv_r(0, 1'b0, 1'b0, 64'h0, 8'h00);
        settle();
        chk("t3_cnt_after", dut.cnt_q, 4'd7);
        chk("t3_unblocked", s2m_ARREADY, 1'b1);
        ar_drive(1'b0, 64'h0, 8'h00, 8'd0, 8'h00);
        slv_r(0, 1'b1, 1'b1, 64'h2, 8'h01);
        repeat (7) cyc();
        slv_r(0, 1'b0, 1'b0, 64'h0, 8'h00);
        settle();
        chk("t3_drained", dut.cnt_q, 4'd0);

        // 4: target switch waits for the drain
        ar_drive(1'b1, 64'h0, 8'h02, 8'd0, 8'h00);
        cyc();
        ar_drive(1'b1, 64'h2000, 8'h03, 8'd0, 8'h00);
        settle();
        chk("t4_switch_blocked", s2m_ARREADY, 1'b0);
        chk("t4_no_m_arvalid", m_ARVALID, 4'b0000);
        cyc();
        slv_r(0, 1'b1, 1'b1, 64'hC0, 8'h02);
        settle();
        chk("t4_blocked_at_rlast", s2m_ARREADY, 1'b0);
        chk("t4_m_rready0", m_RREADY, 4'b0001);
        cyc();
        slv_r(0, 1'b0, 1'b0, 64'h0, 8'h00);
        settle();
        chk("t4_m_arvalid2", m_ARVALID, 4'b0100);
        chk("t4_arready", s2m_ARREADY, 1'b1);
        cyc();
        ar_drive(1'b0, 64'h0, 8'h00, 8'd0, 8'h00);
        slv_r(2, 1'b1, 1'b1, 64'hC2, 8'h03);
        settle();
        chk("t4_m_rready2", m_RREADY, 4'b0100);
        chk("t4_rdata2", s2m_RDATA, 64'hC2);
        cyc();
        slv_r(2, 1'b0, 1'b0, 64'h0, 8'h00);
        settle();
        chk("t4_drained", dut.cnt_q, 4'd0);

        // 5: simultaneous AR and RLAST handshakes leave cnt unchanged
        ar_drive(1'b1, 64'h3000, 8'h04, 8'd0, 8'h00);
        repeat (3) cyc();
        slv_r(3, 1'b1, 1'b1, 64'hD3, 8'h04);
        settle();
        chk("t5_cnt_before", dut.cnt_q, 4'd3);
        chk("t5_arready", s2m_ARREADY, 1'b1);
        chk("t5_rvalid", s2m_RVALID, 1'b1);
        cyc();
        ar_drive(1'b0, 64'h0, 8'h00, 8'd0, 8'h00);
        settle();
        chk("t5_cnt_same", dut.cnt_q, 4'd3);
        repeat (3) cyc();
        slv_r(3, 1'b0, 1'b0, 64'h0, 8'h00);
        settle();
        chk("t5_drained", dut.cnt_q, 4'd0);

        // 6: reset mid-burst
        s2m_RREADY = 1'b0;
        ar_drive(1'b1, 64'h1000, 8'h06, 8'd3, 8'h00);
        cyc(); cyc();
        ar_drive(1'b0, 64'h0, 8'h00, 8'd0, 8'h00);
        slv_r(1, 1'b1, 1'b0, 64'hBB, 8'h06);
        slv_r(0, 1'b0, 1'b0, 64'h55AA, 8'h00);
        settle();
        chk("t6_cnt_before", dut.cnt_q, 4'd2);
        chk("t6_rdata_before", s2m_RDATA, 64'hBB);
        ARESET = 1'b1;
        cyc();
        s2m_RREADY = 1'b1;
        settle();
        chk("t6_cnt_reset", dut.cnt_q, 4'd0);
        chk("t6_rvalid_reset", s2m_RVALID, 1'b0);
        chk("t6_m_rready_reset", m_RREADY, 4'b0000);
        chk("t6_rdata_slave0", s2m_RDATA, 64'h55AA);
        ARESET = 1'b0;
        slv_r(1, 1'b0, 1'b0, 64'h0, 8'h00);
        ar_drive(1'b1, 64'h9000, 8'h07, 8'd0, 8'h11);
        settle();
        chk("t6_dec_idle", s2m_ARREADY, 1'b1);
        cyc();
        ar_drive(1'b0, 64'h0, 8'h00, 8'd0, 8'h00);
        settle();
        chk("t6_dec_rvalid", s2m_RVALID, 1'b1);
        chk("t6_dec_rlast", s2m_RLAST, 1'b1);
        chk("t6_dec_rid", s2m_RID, 8'h07);
        cyc();
        settle();
        chk("t6_final_cnt", dut.cnt_q, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
